parking_lot_top_module: RTL and testbench

- Car-park occupancy counter driven by two optical sensors, A (outer) and B (inner), across a single-lane gate.
- Synchronises both sensors and tracks the A/B pattern with a direction-detecting FSM.
- Increments the occupancy on a complete entry sequence and decrements it on a complete exit sequence.
- Top level of the parking subsystem; no_cars feeds display/status logic.

---
 rtl/parking_pkg.sv | 35 +++
 rtl/parking_dir_fsm.sv | 122 ++++++++++++
 rtl/parking_lot_top_module.sv | 81 ++++++++
 tb/tb_parking_lot_top_module.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared types and constants for the car-park occupancy
//                counter. Holds the direction FSM state encoding, the {A,B}
//                sensor pattern constants and the default counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    // Default occupancy counter sizing (MAX_CARS must fit in CNT_W bits).
    localparam int CNT_W_DEF    = 4;
    localparam int MAX_CARS_DEF = 15;

    // Synchronised sensor patterns, ordered {a_s, b_s}; 1 = beam blocked.
    localparam logic [1:0] S_00 = 2'b00;
    localparam logic [1:0] S_10 = 2'b10;
    localparam logic [1:0] S_11 = 2'b11;
    localparam logic [1:0] S_01 = 2'b01;

    // Direction FSM states. ENx follow an entering car (outer beam first),
    // EXx follow a leaving car (inner beam first). ERR absorbs illegal jumps.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        ERR  = 3'd7
    } state_t;

endpackage : parking_pkg
`default_nettype wire

// File: rtl/parking_dir_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : parking_dir_fsm
//  Description : Direction-detecting FSM for the two-beam gate. Follows the
//                synchronised {a_s,b_s} pattern along the entry path
//                00->10->11->01->00 or the exit path 00->01->11->10->00,
//                allowing dwell and one-step back-ups. Emits a one-cycle
//                car_in / car_out pulse, combinationally, in the cycle the
//                completing 00 is seen, so the counter updates on the same
//                edge the FSM returns to IDLE.
//  Ports       : clk     - system clock
//                reset   - synchronous active-high reset (to IDLE)
//                a_s     - synchronised outer sensor
//                b_s     - synchronised inner sensor
//                car_in  - one-cycle pulse, complete entry
//                car_out - one-cycle pulse, complete exit
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_dir_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_s,
    input  logic b_s,
    output logic car_in,
    output logic car_out
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] ab_w;

    assign ab_w = {a_s, b_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every state first checks for "unchanged" (hold), then the legal
    // forward/backward neighbours and 00; anything else is an illegal jump.
    always_comb begin
        state_d = state_q;
        car_in  = 1'b0;
        car_out = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab_w)
                    S_00:    state_d = IDLE;
                    S_10:    state_d = EN1;
                    S_01:    state_d = EX1;
                    default: state_d = ERR;
                endcase
            end
            EN1: begin
                case (ab_w)
                    S_10:    state_d = EN1;
                    S_11:    state_d = EN2;
                    S_00:    state_d = IDLE;
                    default: state_d = ERR;
                endcase
            end
            EN2: begin
                case (ab_w)
                    S_11:    state_d = EN2;
                    S_01:    state_d = EN3;
                    S_10:    state_d = EN1;
                    default: state_d = IDLE;   // S_00: abort
                endcase
            end
            EN3: begin
                case (ab_w)
                    S_01:    state_d = EN3;
                    S_11:    state_d = EN2;
                    S_00: begin
                        state_d = IDLE;
                        car_in  = 1'b1;
                    end
                    default: state_d = ERR;
                endcase
            end
            EX1: begin
                case (ab_w)
                    S_01:    state_d = EX1;
                    S_11:    state_d = EX2;
                    S_00:    state_d = IDLE;
                    default: state_d = ERR;
                endcase
            end
            EX2: begin
                case (ab_w)
                    S_11:    state_d = EX2;
                    S_10:    state_d = EX3;
                    S_01:    state_d = EX1;
                    default: state_d = IDLE;   // S_00: abort
                endcase
            end
            EX3: begin
                case (ab_w)
                    S_10:    state_d = EX3;
                    S_11:    state_d = EX2;
                    S_00: begin
                        state_d = IDLE;
                        car_out = 1'b1;
                    end
                    default: state_d = ERR;
                endcase
            end
            default: begin                      // ERR: wait for a clear gate
                if (ab_w == S_00) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

endmodule : parking_dir_fsm
`default_nettype wire

// File: rtl/parking_lot_top_module.sv
`default_nettype none
// ============================================================================
//  Module      : parking_lot_top_module
//  Description : Car-park occupancy counter. Synchronises the asynchronous
//                A (outer) and B (inner) beam sensors through two flops
//                each, feeds them to the direction FSM and keeps a
//                saturating occupancy count (0 .. MAX_CARS).
//  Ports       : clk     - system clock, rising edge
//                reset   - synchronous active-high reset
//                A       - outer sensor, 1 = blocked, asynchronous
//                B       - inner sensor, 1 = blocked, asynchronous
//                no_cars - registered current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_lot_top_module
    import parking_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_CARS = MAX_CARS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             B,
    output logic [CNT_W-1:0] no_cars
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CARS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Two-flop synchronisers, bit 1 = A, bit 0 = B.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic             car_in_w;
    logic             car_out_w;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {A, B};
            sync2_q <= sync1_q;
        end
    end

    parking_dir_fsm u_dir_fsm (
        .clk     (clk),
        .reset   (reset),
        .a_s     (sync2_q[1]),
        .b_s     (sync2_q[0]),
        .car_in  (car_in_w),
        .car_out (car_out_w)
    );

    // Saturating counter: increments stop at MAX_CARS, decrements at 0.
    // car_in and car_out come from distinct FSM states, so never coincide.
    always_comb begin
        count_d = count_q;
        if (car_in_w && (count_q < CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else if (car_out_w && (count_q != CNT_ZERO)) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign no_cars = count_q;

endmodule : parking_lot_top_module
`default_nettype wire

// File: tb/tb_parking_lot_top_module.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_parking_lot_top_module
//  Description : Self-checking bench for the car-park counter. Directed
//                scenarios plus a randomised walk over the sensor patterns,
//                compared against a path-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_lot_top_module;

    localparam int CNT_W    = 4;
    localparam int MAX_CARS = 15;

    logic             clk;
    logic             reset;
    logic             A;
    logic             B;
    logic [CNT_W-1:0] no_cars;

    int n_total;
    int n_bad;

    // Reference model: a car is a walk along a path of patterns.
    // m_dir: 0 = gate clear, 1 = entering, 2 = leaving, 3 = illegal.
    // m_pos: index (1..3) of the current pattern along that path.
    int         m_dir;
    int         m_pos;
    int         m_cnt;
    logic [1:0] m_last;
    logic [1:0] path_en [4];
    logic [1:0] path_ex [4];

    parking_lot_top_module #(
        .CNT_W    (CNT_W),
        .MAX_CARS (MAX_CARS)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .no_cars (no_cars)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int path_index(input int dir, input logic [1:0] p);
        for (int k = 1; k < 4; k++) begin
            if ((dir == 1 && path_en[k] == p) || (dir == 2 && path_ex[k] == p))
                return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [1:0] p);
        int idx;
        if (p == m_last) return;
        m_last = p;
        if (p == 2'b00) begin
            if (m_pos == 3 && m_dir == 1 && m_cnt < MAX_CARS) m_cnt++;
            if (m_pos == 3 && m_dir == 2 && m_cnt > 0)        m_cnt--;
            m_dir = 0;
            m_pos = 0;
            return;
        end
        if (m_dir == 3) return;
        if (m_dir == 0) begin
            if (p == 2'b10)      begin m_dir = 1; m_pos = 1; end
            else if (p == 2'b01) begin m_dir = 2; m_pos = 1; end
            else                 m_dir = 3;
            return;
        end
        idx = path_index(m_dir, p);
        if (idx == m_pos + 1 || idx == m_pos - 1) m_pos = idx;
        else                                      m_dir = 3;
    endtask

    // Drive a pattern at the falling edge and hold it for 'hold' rising edges.
    task automatic apply(input logic [1:0] p, input int hold);
        @(negedge clk);
        {A, B} = p;
        model_step(p);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    // Up to 8 patterns, first element in the top bits.
    task automatic run_seq(input logic [15:0] s, input int n);
        for (int k = 0; k < n; k++) apply(s[15-2*k -: 2], 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt  = 0;
        m_dir  = 0;
        m_pos  = 0;
        m_last = 2'b00;
        model_step({A, B});
        #1;
    endtask

    localparam logic [15:0] SEQ_ENTRY  = {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 6'b0};
    localparam logic [15:0] SEQ_EXIT   = {2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 6'b0};
    localparam logic [15:0] SEQ_REVRS  = {2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 6'b0};
    localparam logic [15:0] SEQ_BACKUP = {2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b0};
    localparam logic [15:0] SEQ_GL1    = {2'b00, 2'b11, 2'b00, 10'b0};
    localparam logic [15:0] SEQ_GL2    = {2'b00, 2'b10, 2'b01, 2'b00, 8'b0};
    localparam logic [15:0] SEQ_TO_EN3 = {2'b00, 2'b10, 2'b11, 2'b01, 8'b0};

    initial begin
        int         gdir;
        int         gpos;
        int         r;
        int         hold;
        int         old_cnt;
        logic [1:0] p;

        path_en = '{2'b00, 2'b10, 2'b11, 2'b01};
        path_ex = '{2'b00, 2'b01, 2'b11, 2'b10};
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        A       = 1'b0;
        B       = 1'b0;

        // Reset state
        do_reset();
        check_eq("reset", int'(no_cars), 0);

        // Two entries then one exit
        run_seq(SEQ_ENTRY, 5);
        check_eq("entry1", int'(no_cars), 1);
        run_seq(SEQ_ENTRY, 5);
        check_eq("entry2", int'(no_cars), 2);
        run_seq(SEQ_EXIT, 5);
        check_eq("exit1", int'(no_cars), 1);

        // Reversing car and backed-up entry
        run_seq(SEQ_REVRS, 5);
        check_eq("reverse", int'(no_cars), 1);
        run_seq(SEQ_BACKUP, 7);
        check_eq("backup", int'(no_cars), 2);

        // Illegal jumps, then a valid entry still counts
        run_seq(SEQ_GL1, 3);
        check_eq("glitch11", int'(no_cars), 2);
        run_seq(SEQ_GL2, 4);
        check_eq("glitch1001", int'(no_cars), 2);
        run_seq(SEQ_ENTRY, 5);
        check_eq("after_glitch", int'(no_cars), 3);

        // Latency: count moves on the 3rd edge after the final 00
        run_seq(SEQ_TO_EN3, 4);
        @(negedge clk);
        {A, B} = 2'b00;
        model_step(2'b00);
        repeat (2) @(posedge clk);
        #1;
        check_eq("lat_edge2", int'(no_cars), 3);
        @(posedge clk);
        #1;
        check_eq("lat_edge3", int'(no_cars), 4);

        // Exit from zero saturates at 0
        do_reset();
        check_eq("reset2", int'(no_cars), 0);
        run_seq(SEQ_EXIT, 5);
        check_eq("exit_at_0", int'(no_cars), 0);

        // Entries saturate at MAX_CARS
        for (int k = 0; k < 16; k++) run_seq(SEQ_ENTRY, 5);
        check_eq("sat_16", int'(no_cars), 15);
        run_seq(SEQ_ENTRY, 5);
        check_eq("sat_17", int'(no_cars), 15);

        // Reset mid-sequence while in EN3 with A=0,B=1 held
        do_reset();
        run_seq(SEQ_TO_EN3, 4);
        check_eq("mid_pre", int'(no_cars), 0);
        do_reset();
        apply(2'b01, 3);
        apply(2'b00, 3);
        check_eq("mid_reset", int'(no_cars), 0);
        run_seq(SEQ_EXIT, 5);
        check_eq("mid_exit", int'(no_cars), 0);

        // Randomised walks along the gate paths with occasional glitches
        do_reset();
        gdir = 1;
        gpos = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                p = 2'($urandom_range(0, 3));
            end else begin
                if (r < 7)       gpos = (gpos + 1) % 4;
                else if (gpos > 0) gpos = gpos - 1;
                if (gpos == 0) gdir = int'($urandom_range(1, 2));
                p = (gdir == 1) ? path_en[gpos] : path_ex[gpos];
            end
            hold = int'($urandom_range(2, 4));
            apply(p, hold);
            if (hold >= 3) check_eq("random", int'(no_cars), m_cnt);
        end
        apply(2'b00, 3);
        check_eq("random_end", int'(no_cars), m_cnt);

        // Idle forever: no change
        old_cnt = m_cnt;
        repeat (20) @(posedge clk);
        #1;
        check_eq("idle_hold", int'(no_cars), old_cnt);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_parking_lot_top_module
`default_nettype wire
